wb_stage_arb: RTL and testbench

//  Parametrised, registered write-back stage. Selects the result source and aligns/extends load data.

---
 rtl/wb_stage_arb_pkg.sv | 27 ++
 rtl/wb_stage_arb_if.sv | 41 ++++
 rtl/wb_load_align.sv | 37 +++
 rtl/wb_stage_arb.sv | 168 ++++++++++++++++
 tb/tb_wb_stage_arb.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_stage_arb_pkg.sv
// Shared types for the write-back stage: source select, load size, arbiter state.
package wb_stage_arb_pkg;

  localparam int DEF_XLEN = 32;
  localparam int DEF_RA_W = 5;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_MEM  = 2'd1,
    WB_LINK = 2'd2,
    WB_IMM  = 2'd3
  } wb_sel_t;

  typedef enum logic [1:0] {
    LD_B = 2'd0,
    LD_H = 2'd1,
    LD_W = 2'd2,
    LD_D = 2'd3
  } ld_size_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_WAIT  = 2'd1,
    ARB_FORCE = 2'd2
  } wb_arb_state_t;

endpackage

// File: rtl/wb_stage_arb_if.sv
// MEM/WB entry and late-result port bundle for the write-back stage.
interface wb_stage_arb_if
  import wb_stage_arb_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int RA_W = DEF_RA_W
);
  localparam int OFF_W = $clog2(XLEN / 8);

  // Handshakes: a transfer happens on a clock edge where valid and ready are both 1;
  // the sender holds valid and its payload stable until that edge, ready never depends on valid.
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       wb_sel;
  logic             reg_write;
  logic [RA_W-1:0]  rd_addr;
  logic [XLEN-1:0]  alu_result;
  logic [XLEN-1:0]  mem_rdata;
  logic [OFF_W-1:0] byte_off;
  logic [1:0]       ld_size;
  logic             ld_unsigned;
  logic [XLEN-1:0]  pc_plus4;
  logic [XLEN-1:0]  imm;
  logic             late_valid;
  logic             late_ready;
  logic [RA_W-1:0]  late_rd;
  logic [XLEN-1:0]  late_data;

  modport master (
    output in_valid, wb_sel, reg_write, rd_addr, alu_result, mem_rdata, byte_off,
           ld_size, ld_unsigned, pc_plus4, imm, late_valid, late_rd, late_data,
    input  in_ready, late_ready
  );

  modport slave (
    input  in_valid, wb_sel, reg_write, rd_addr, alu_result, mem_rdata, byte_off,
           ld_size, ld_unsigned, pc_plus4, imm, late_valid, late_rd, late_data,
    output in_ready, late_ready
  );

endinterface

// File: rtl/wb_load_align.sv
// Load data alignment: shift the raw word down to the addressed byte, then
// truncate to the access size and sign- or zero-extend.
module wb_load_align
  import wb_stage_arb_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int OFF_W = $clog2(XLEN / 8)
) (
  input  logic [XLEN-1:0]  mem_rdata,
  input  logic [OFF_W-1:0] byte_off,
  input  logic [1:0]       ld_size,
  input  logic             ld_unsigned,
  output logic [XLEN-1:0]  ld_data
);

  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] mask;
  logic [XLEN-1:0] msb;
  logic            sbit;

  always_comb begin
    shifted = mem_rdata >> {byte_off, 3'b000};
    mask    = '1;
    case (ld_size_t'(ld_size))
      LD_B:    mask = {XLEN{1'b1}} >> (XLEN - 8);
      LD_H:    mask = {XLEN{1'b1}} >> (XLEN - 16);
      LD_W:    mask = {XLEN{1'b1}} >> (XLEN - 32);
      default: mask = '1;
    endcase
    // The sign bit is the top bit inside the access-size mask.
    msb     = mask & ~(mask >> 1);
    sbit    = |(shifted & msb);
    ld_data = shifted & mask;
    if (!ld_unsigned && sbit) ld_data = ld_data | ~mask;
  end

endmodule

// File: rtl/wb_stage_arb.sv
// Registered write-back stage arbitrating the register-file write port between the
// in-order pipe and a held late result. Optional same-cycle bypass: WB_FWD_EN.
module wb_stage_arb
  import wb_stage_arb_pkg::*;
#(
  parameter int XLEN       = DEF_XLEN,
  parameter int RA_W       = DEF_RA_W,
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 32
) (
  input  logic                clk,
  input  logic                rst,
  wb_stage_arb_if.slave       bus,
  output logic                rf_we,
  output logic [RA_W-1:0]     rf_waddr,
  output logic [XLEN-1:0]     rf_wdata,
  output logic [CNT_W-1:0]    retired_cnt,
  output logic                fwd_valid,
  output logic [RA_W-1:0]     fwd_addr,
  output logic [XLEN-1:0]     fwd_data,
  output wb_arb_state_t       dbg_state
);

  localparam int OFF_W = $clog2(XLEN / 8);
  localparam int AGE_W = $clog2(STARVE_MAX + 1);
  localparam logic [AGE_W-1:0] AGE_LIMIT = AGE_W'(STARVE_MAX - 1);

  wb_arb_state_t   state, state_n;
  logic [AGE_W-1:0] age, age_n;

  logic            hold_valid;
  logic [RA_W-1:0] hold_rd;
  logic [XLEN-1:0] hold_data;

  logic            in_ready;
  logic            late_ready;
  logic            accept;
  logic            pwr;
  logic            capture;
  logic            drain;
  logic [XLEN-1:0] ld_data;
  logic [XLEN-1:0] src;

  assign in_ready       = !rst && (state != ARB_FORCE);
  assign late_ready     = !rst && !hold_valid;
  assign bus.in_ready   = in_ready;
  assign bus.late_ready = late_ready;

  assign accept  = bus.in_valid && in_ready;
  assign pwr     = accept && bus.reg_write && (bus.rd_addr != '0);
  assign capture = bus.late_valid && late_ready;
  // The hold entry owns the write port whenever the pipe does not write.
  assign drain   = hold_valid && !pwr;

  wb_load_align #(.XLEN(XLEN), .OFF_W(OFF_W)) u_align (
    .mem_rdata   (bus.mem_rdata),
    .byte_off    (bus.byte_off),
    .ld_size     (bus.ld_size),
    .ld_unsigned (bus.ld_unsigned),
    .ld_data     (ld_data)
  );

  always_comb begin
    src = bus.alu_result;
    case (wb_sel_t'(bus.wb_sel))
      WB_ALU:  src = bus.alu_result;
      WB_MEM:  src = ld_data;
      WB_LINK: src = bus.pc_plus4;
      WB_IMM:  src = bus.imm;
      default: src = bus.alu_result;
    endcase
  end

  always_comb begin
    state_n = state;
    age_n   = age;
    case (state)
      ARB_IDLE: begin
        if (capture) begin
          state_n = ARB_WAIT;
          age_n   = '0;
        end
      end
      ARB_WAIT: begin
        if (drain) begin
          state_n = ARB_IDLE;
          age_n   = '0;
        end else begin
          age_n = age + AGE_W'(1);
          if (age_n >= AGE_LIMIT) state_n = ARB_FORCE;
        end
      end
      ARB_FORCE: begin
        // in_ready is low here, so the hold entry is guaranteed to drain.
        state_n = ARB_IDLE;
        age_n   = '0;
      end
      default: begin
        state_n = ARB_IDLE;
        age_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB_IDLE;
      age   <= '0;
    end else begin
      state <= state_n;
      age   <= age_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_rd    <= '0;
      hold_data  <= '0;
    end else if (capture) begin
      hold_valid <= 1'b1;
      hold_rd    <= bus.late_rd;
      hold_data  <= bus.late_data;
    end else if (drain) begin
      hold_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (pwr) begin
      rf_we    <= 1'b1;
      rf_waddr <= bus.rd_addr;
      rf_wdata <= src;
    end else if (hold_valid && (hold_rd != '0)) begin
      rf_we    <= 1'b1;
      rf_waddr <= hold_rd;
      rf_wdata <= hold_data;
    end else begin
      rf_we    <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) retired_cnt <= '0;
    else if (accept) retired_cnt <= retired_cnt + CNT_W'(1);
  end

`ifdef WB_FWD_EN
  assign fwd_valid = pwr;
  assign fwd_addr  = bus.rd_addr;
  assign fwd_data  = src;
`else
  assign fwd_valid = 1'b0;
  assign fwd_addr  = '0;
  assign fwd_data  = '0;
`endif

  assign dbg_state = state;

  // The upstream scoreboard never lets a pipe write race the held late result.
  a_no_waw : assert property (@(posedge clk) disable iff (rst)
    !(hold_valid && pwr && (bus.rd_addr == hold_rd)));

endmodule

// File: tb/tb_wb_stage_arb.sv
// Bench for wb_stage_arb: vector table, random ALU/LINK/IMM/MEM traffic and
// hand sequences for the late-result hold, starvation stall and reset.
module tb_wb_stage_arb;
  import wb_stage_arb_pkg::*;

  localparam int XLEN  = 32;
  localparam int RA_W  = 5;
  localparam int CNT_W = 32;
  localparam int SW    = 1 + RA_W + XLEN + CNT_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_stage_arb_if #(.XLEN(XLEN), .RA_W(RA_W)) bus ();

  logic             rf_we;
  logic [RA_W-1:0]  rf_waddr;
  logic [XLEN-1:0]  rf_wdata;
  logic [CNT_W-1:0] retired_cnt;
  logic             fwd_valid;
  logic [RA_W-1:0]  fwd_addr;
  logic [XLEN-1:0]  fwd_data;
  wb_arb_state_t    dbg_state;

  wb_stage_arb #(.XLEN(XLEN), .RA_W(RA_W), .STARVE_MAX(4), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .retired_cnt (retired_cnt),
    .fwd_valid   (fwd_valid),
    .fwd_addr    (fwd_addr),
    .fwd_data    (fwd_data),
    .dbg_state   (dbg_state)
  );

  typedef struct {
    logic        v;
    logic [1:0]  sel;
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [1:0]  off;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] pc4;
    logic [31:0] imm;
    logic        ewe;
    logic [31:0] edata;
  } vec_t;

  vec_t tbl[15];

  logic [SW-1:0]    exp_q[$];
  int               n_vec = 0;
  int               n_err = 0;
  logic [RA_W-1:0]  m_addr;
  logic [XLEN-1:0]  m_data;
  logic [CNT_W-1:0] m_cnt;

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic expect_cycle(input logic we, input logic [RA_W-1:0] a,
                              input logic [XLEN-1:0] d, input logic acc);
    if (we) begin
      m_addr = a;
      m_data = d;
    end
    if (acc) m_cnt = m_cnt + 1;
    exp_q.push_back({we, m_addr, m_data, m_cnt});
  endtask

  task automatic expect_reset();
    m_addr = '0;
    m_data = '0;
    m_cnt  = '0;
    exp_q.push_back({1'b0, m_addr, m_data, m_cnt});
  endtask

  task automatic tick(input string nm);
    logic [SW-1:0] e;
    @(posedge clk);
    #1;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: scoreboard empty at output", nm);
    end else begin
      e = exp_q.pop_front();
      if ({rf_we, rf_waddr, rf_wdata, retired_cnt} !== e) begin
        n_err++;
        $display("FAIL %s: got we=%0b addr=%0d data=%h cnt=%0d expected we=%0b addr=%0d data=%h cnt=%0d",
                 nm, rf_we, rf_waddr, rf_wdata, retired_cnt,
                 e[SW-1], e[SW-2 -: RA_W], e[XLEN+CNT_W-1 -: XLEN], e[CNT_W-1:0]);
      end
    end
  endtask

  // ---------------- drivers ----------------
  task automatic idle_inputs();
    bus.in_valid    = 1'b0;
    bus.wb_sel      = WB_ALU;
    bus.reg_write   = 1'b0;
    bus.rd_addr     = '0;
    bus.alu_result  = '0;
    bus.mem_rdata   = '0;
    bus.byte_off    = '0;
    bus.ld_size     = LD_W;
    bus.ld_unsigned = 1'b0;
    bus.pc_plus4    = '0;
    bus.imm         = '0;
    bus.late_valid  = 1'b0;
    bus.late_rd     = '0;
    bus.late_data   = '0;
  endtask

  task automatic set_pipe(input logic v, input logic [RA_W-1:0] rd, input logic [XLEN-1:0] val);
    bus.in_valid   = v;
    bus.wb_sel     = WB_ALU;
    bus.reg_write  = 1'b1;
    bus.rd_addr    = rd;
    bus.alu_result = val;
    bus.pc_plus4   = ~val;
    bus.imm        = val ^ 32'h5A5A_5A5A;
    bus.mem_rdata  = 32'h0F0F_0F0F;
  endtask

  function automatic logic [31:0] ld_model(input logic [31:0] mem, input logic [1:0] off,
                                           input logic [1:0] sz, input logic uns);
    logic [31:0] w;
    w = mem >> (8 * off);
    case (sz)
      2'd0:    return uns ? {24'h0, w[7:0]}  : {{24{w[7]}}, w[7:0]};
      2'd1:    return uns ? {16'h0, w[15:0]} : {{16{w[15]}}, w[15:0]};
      default: return w;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // {v, sel, rw, rd, alu, mem, off, sz, uns, pc4, imm, exp_we, exp_data}
    tbl[0]  = '{1'b1, WB_MEM,  1'b1, 5'd5,  32'h1111_1111, 32'h8000_00F0, 2'd0, LD_B, 1'b0, 32'h2222_2222, 32'h3333_3333, 1'b1, 32'hFFFF_FFF0};
    tbl[1]  = '{1'b1, WB_MEM,  1'b1, 5'd5,  32'h1111_1111, 32'h8000_00F0, 2'd0, LD_B, 1'b1, 32'h2222_2222, 32'h3333_3333, 1'b1, 32'h0000_00F0};
    tbl[2]  = '{1'b1, WB_ALU,  1'b1, 5'd0,  32'h1234_5678, 32'h0,         2'd0, LD_W, 1'b0, 32'h0,         32'h0,         1'b0, 32'h0};
    tbl[3]  = '{1'b1, WB_ALU,  1'b1, 5'd3,  32'hDEAD_BEEF, 32'h4444_4444, 2'd0, LD_W, 1'b0, 32'h2222_2222, 32'h3333_3333, 1'b1, 32'hDEAD_BEEF};
    tbl[4]  = '{1'b1, WB_MEM,  1'b1, 5'd4,  32'h1111_1111, 32'h8765_4321, 2'd2, LD_H, 1'b0, 32'h2222_2222, 32'h3333_3333, 1'b1, 32'hFFFF_8765};
    tbl[5]  = '{1'b1, WB_MEM,  1'b1, 5'd4,  32'h1111_1111, 32'h8765_4321, 2'd2, LD_H, 1'b1, 32'h2222_2222, 32'h3333_3333, 1'b1, 32'h0000_8765};
    tbl[6]  = '{1'b1, WB_MEM,  1'b1, 5'd6,  32'h1111_1111, 32'h1234_8000, 2'd1, LD_B, 1'b0, 32'h2222_2222, 32'h3333_3333, 1'b1, 32'hFFFF_FF80};
    tbl[7]  = '{1'b1, WB_MEM,  1'b1, 5'd7,  32'h1111_1111, 32'h7F00_0000, 2'd3, LD_B, 1'b0, 32'h2222_2222, 32'h3333_3333, 1'b1, 32'h0000_007F};
    tbl[8]  = '{1'b1, WB_MEM,  1'b1, 5'd8,  32'h1111_1111, 32'hCAFE_F00D, 2'd0, LD_W, 1'b0, 32'h2222_2222, 32'h3333_3333, 1'b1, 32'hCAFE_F00D};
    tbl[9]  = '{1'b1, WB_MEM,  1'b1, 5'd9,  32'h1111_1111, 32'h00AB_CD00, 2'd1, LD_H, 1'b0, 32'h2222_2222, 32'h3333_3333, 1'b1, 32'hFFFF_ABCD};
    tbl[10] = '{1'b1, WB_LINK, 1'b1, 5'd1,  32'h1111_1111, 32'h4444_4444, 2'd0, LD_W, 1'b0, 32'h0000_0104, 32'h3333_3333, 1'b1, 32'h0000_0104};
    tbl[11] = '{1'b1, WB_IMM,  1'b1, 5'd2,  32'h1111_1111, 32'h4444_4444, 2'd0, LD_W, 1'b0, 32'h2222_2222, 32'hABCD_E000, 1'b1, 32'hABCD_E000};
    tbl[12] = '{1'b0, WB_ALU,  1'b1, 5'd10, 32'h0000_0055, 32'h0,         2'd0, LD_W, 1'b0, 32'h0,         32'h0,         1'b0, 32'h0};
    tbl[13] = '{1'b1, WB_ALU,  1'b0, 5'd11, 32'h0000_0077, 32'h0,         2'd0, LD_W, 1'b0, 32'h0,         32'h0,         1'b0, 32'h0};
    tbl[14] = '{1'b1, WB_ALU,  1'b1, 5'd31, 32'hFFFF_FFFF, 32'h0,         2'd0, LD_W, 1'b0, 32'h0,         32'h0,         1'b1, 32'hFFFF_FFFF};

    // ---------------- reset ----------------
    rst = 1'b1;
    idle_inputs();
    expect_reset();
    tick("reset0");
    chk("in_ready in reset", 64'(bus.in_ready), 64'd0);
    chk("late_ready in reset", 64'(bus.late_ready), 64'd0);
    chk("state after reset", 64'(dbg_state), 64'(ARB_IDLE));
    expect_reset();
    tick("reset1");
    rst = 1'b0;
    #1;
    chk("in_ready after reset", 64'(bus.in_ready), 64'd1);
    chk("late_ready after reset", 64'(bus.late_ready), 64'd1);

    // ---------------- vector table ----------------
    for (int i = 0; i < 15; i++) begin
      bus.in_valid    = tbl[i].v;
      bus.wb_sel      = tbl[i].sel;
      bus.reg_write   = tbl[i].rw;
      bus.rd_addr     = tbl[i].rd;
      bus.alu_result  = tbl[i].alu;
      bus.mem_rdata   = tbl[i].mem;
      bus.byte_off    = tbl[i].off;
      bus.ld_size     = tbl[i].sz;
      bus.ld_unsigned = tbl[i].uns;
      bus.pc_plus4    = tbl[i].pc4;
      bus.imm         = tbl[i].imm;
      expect_cycle(tbl[i].ewe, tbl[i].rd, tbl[i].edata, tbl[i].v);
      #1;
`ifdef WB_FWD_EN
      chk($sformatf("vec%0d fwd_valid", i), 64'(fwd_valid), 64'(tbl[i].ewe));
      if (tbl[i].ewe) begin
        chk($sformatf("vec%0d fwd_addr", i), 64'(fwd_addr), 64'(tbl[i].rd));
        chk($sformatf("vec%0d fwd_data", i), 64'(fwd_data), 64'(tbl[i].edata));
      end
`else
      chk($sformatf("vec%0d fwd_valid", i), 64'(fwd_valid), 64'd0);
      chk($sformatf("vec%0d fwd_addr", i), 64'(fwd_addr), 64'd0);
      chk($sformatf("vec%0d fwd_data", i), 64'(fwd_data), 64'd0);
`endif
      tick($sformatf("vec%0d rf", i));
    end

    // ---------------- random pipe traffic ----------------
    for (int k = 0; k < 40; k++) begin
      logic [XLEN-1:0] val;
      logic            pw;
      bus.in_valid    = 1'($urandom_range(0, 3) != 0);
      bus.wb_sel      = 2'($urandom_range(0, 3));
      bus.reg_write   = 1'($urandom_range(0, 1));
      bus.rd_addr     = 5'($urandom_range(0, 31));
      bus.alu_result  = $urandom;
      bus.mem_rdata   = $urandom;
      bus.byte_off    = 2'($urandom_range(0, 3));
      bus.ld_size     = 2'($urandom_range(0, 2));
      bus.ld_unsigned = 1'($urandom_range(0, 1));
      bus.pc_plus4    = $urandom;
      bus.imm         = $urandom;
      case (bus.wb_sel)
        2'd0:    val = bus.alu_result;
        2'd1:    val = ld_model(bus.mem_rdata, bus.byte_off, bus.ld_size, bus.ld_unsigned);
        2'd2:    val = bus.pc_plus4;
        default: val = bus.imm;
      endcase
      pw = bus.in_valid && bus.reg_write && (bus.rd_addr != 0);
      expect_cycle(pw, bus.rd_addr, val, bus.in_valid);
      tick($sformatf("rand%0d", k));
    end

    // ---------------- late result on an idle pipe ----------------
    idle_inputs();
    expect_cycle(1'b0, '0, '0, 1'b0);
    tick("t3 settle");
    chk("t3 late_ready before", 64'(bus.late_ready), 64'd1);
    bus.late_valid = 1'b1;
    bus.late_rd    = 5'd7;
    bus.late_data  = 32'h0000_ABCD;
    expect_cycle(1'b0, '0, '0, 1'b0);
    tick("t3 capture");
    bus.late_valid = 1'b0;
    chk("t3 late_ready held", 64'(bus.late_ready), 64'd0);
    chk("t3 state wait", 64'(dbg_state), 64'(ARB_WAIT));
    expect_cycle(1'b1, 5'd7, 32'h0000_ABCD, 1'b0);
    tick("t3 drain");
    chk("t3 late_ready back", 64'(bus.late_ready), 64'd1);
    chk("t3 state idle", 64'(dbg_state), 64'(ARB_IDLE));
    expect_cycle(1'b0, '0, '0, 1'b0);
    tick("t3 quiet");

    // ---------------- starvation stall ----------------
    set_pipe(1'b1, 5'd1, 32'h0000_0101);
    bus.late_valid = 1'b1;
    bus.late_rd    = 5'd9;
    bus.late_data  = 32'h0000_9999;
    chk("t4 ready c0", 64'(bus.in_ready), 64'd1);
    expect_cycle(1'b1, 5'd1, 32'h0000_0101, 1'b1);
    tick("t4 c0");
    bus.late_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      set_pipe(1'b1, 5'(k + 1), 32'h0000_0100 + 32'(k + 1));
      chk($sformatf("t4 ready blocked%0d", k), 64'(bus.in_ready), 64'd1);
      chk($sformatf("t4 state blocked%0d", k), 64'(dbg_state), 64'(ARB_WAIT));
      expect_cycle(1'b1, 5'(k + 1), 32'h0000_0100 + 32'(k + 1), 1'b1);
      tick($sformatf("t4 c%0d", k));
    end
    set_pipe(1'b1, 5'd5, 32'h0000_0105);
    chk("t4 ready forced", 64'(bus.in_ready), 64'd0);
    chk("t4 state force", 64'(dbg_state), 64'(ARB_FORCE));
    expect_cycle(1'b1, 5'd9, 32'h0000_9999, 1'b0);
    tick("t4 forced write");
    chk("t4 ready restored", 64'(bus.in_ready), 64'd1);
    chk("t4 state idle", 64'(dbg_state), 64'(ARB_IDLE));
    expect_cycle(1'b1, 5'd5, 32'h0000_0105, 1'b1);
    tick("t4 c5");
    idle_inputs();
    expect_cycle(1'b0, '0, '0, 1'b0);
    tick("t4 quiet");

    // ---------------- reset with a pending hold ----------------
    set_pipe(1'b1, 5'd1, 32'h0000_0011);
    bus.late_valid = 1'b1;
    bus.late_rd    = 5'd12;
    bus.late_data  = 32'h0000_1212;
    expect_cycle(1'b1, 5'd1, 32'h0000_0011, 1'b1);
    tick("t5 capture");
    bus.late_valid = 1'b0;
    set_pipe(1'b1, 5'd2, 32'h0000_0022);
    chk("t5 state wait", 64'(dbg_state), 64'(ARB_WAIT));
    rst = 1'b1;
    #1;
    chk("t5 in_ready in reset", 64'(bus.in_ready), 64'd0);
    chk("t5 late_ready in reset", 64'(bus.late_ready), 64'd0);
    expect_reset();
    tick("t5 reset");
    chk("t5 state idle", 64'(dbg_state), 64'(ARB_IDLE));
    rst = 1'b0;
    idle_inputs();
    #1;
    chk("t5 late_ready after", 64'(bus.late_ready), 64'd1);
    expect_cycle(1'b0, '0, '0, 1'b0);
    tick("t5 no stale write");
    expect_cycle(1'b0, '0, '0, 1'b0);
    tick("t5 quiet");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
